ls_exec: RTL and testbench

Load/store execute stage directly downstream of the load-store station. It takes one in-order issued memory op per handshake, computes the effective address, and performs loads against the data-memory port. Stores are parked in a 4-entry store buffer until ROB commit, and every op's completion is reported to the CDB. It back-pressures the station through `stall_issue` and honours branch/jump recovery by ROB number.

---
 rtl/ls_exec_pkg.sv | 29 ++
 rtl/ls_store_buffer.sv | 134 +++++++++++++
 rtl/ls_exec.sv | 209 ++++++++++++++++++++
 tb/tb_ls_exec.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_exec_pkg.sv
// ls_exec_pkg: shared types and constants for the load/store execute stage.
//   state_e    - top-level FSM states (IDLE, LD, CDB)
//   port_own_e - which requester currently owns the data-memory port
//   sb_entry_t - one store-buffer slot
package ls_exec_pkg;

   localparam int SB_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE,
      LD,
      CDB
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_LOAD,
      OWN_DRAIN
   } port_own_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  rob;
      logic        committed;
      logic        killed;
   } sb_entry_t;

endpackage

// File: rtl/ls_store_buffer.sv
// ls_store_buffer: in-order store FIFO that parks stores until ROB commit.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   enq_i/enq_addr_i/...     - enqueue a store at the tail
//   commit_i                 - mark oldest live uncommitted entry committed
//   recover_i, rob_num_rec_i - kill the uncommitted entry with this ROB tag
//   ld_addr_i, hazard_o      - word-address match against live entries
//   drain_req_o/addr/data    - committed, live head wants a memory write
//   drain_ack_i              - head write completed, dequeue it
//   full_o                   - all DEPTH slots occupied
module ls_store_buffer
   import ls_exec_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enq_i,
   input  logic [31:0] enq_addr_i,
   input  logic [31:0] enq_data_i,
   input  logic [3:0]  enq_rob_i,
   input  logic        commit_i,
   input  logic        recover_i,
   input  logic [3:0]  rob_num_rec_i,
   input  logic [31:0] ld_addr_i,
   input  logic        drain_ack_i,
   output logic        full_o,
   output logic        hazard_o,
   output logic        drain_req_o,
   output logic [31:0] drain_addr_o,
   output logic [31:0] drain_data_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   sb_entry_t        ent_q [DEPTH];
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] cmt_sel;
   logic [PW-1:0]    cmt_idx;
   logic             cmt_found;
   sb_entry_t        head;
   logic             head_valid;
   logic             enq_ok;
   logic             deq;

   // Slot i is occupied when its distance from the head is below the count.
   // NOTE: every variable in an always_comb gets a default first so no path
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ({1'b0, PW'(i) - head_q} < count_q);
      end
   end

   // Commit target: oldest occupied entry that is neither committed nor
   // killed. Scanning only occupied slots means a same-cycle enqueue can
   // never be the target.
   always_comb begin
      cmt_sel   = '0;
      cmt_found = 1'b0;
      cmt_idx   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         cmt_idx = head_q + PW'(k);
         if (!cmt_found && valid[cmt_idx] &&
             !ent_q[cmt_idx].committed && !ent_q[cmt_idx].killed) begin
            cmt_sel[cmt_idx] = commit_i;
            cmt_found        = 1'b1;
         end
      end
   end

   // Killed stores never reach memory, so they cannot block a load.
   always_comb begin
      hazard_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && !ent_q[i].killed &&
             (ent_q[i].addr[31:2] == ld_addr_i[31:2])) begin
            hazard_o = 1'b1;
         end
      end
   end

   assign head         = ent_q[head_q];
   assign head_valid   = (count_q != '0);
   assign full_o       = (count_q == CW'(DEPTH));
   assign enq_ok       = enq_i && !full_o;
   assign drain_req_o  = head_valid && head.committed && !head.killed;
   assign drain_addr_o = head.addr;
   assign drain_data_o = head.data;
   // A killed head leaves in one cycle without a memory access.
   assign deq          = (head_valid && head.killed) || (drain_req_o && drain_ack_i);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         // NOTE: the array is reset as well so no stale committed/killed
         // flags survive into a fresh run.
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (cmt_sel[i]) begin
               ent_q[i].committed <= 1'b1;
            end else if (recover_i && valid[i] && !ent_q[i].committed &&
                         (ent_q[i].rob == rob_num_rec_i)) begin
               ent_q[i].killed <= 1'b1;
            end
         end
         if (enq_ok) begin
            ent_q[tail_q] <= '{addr: enq_addr_i, data: enq_data_i, rob: enq_rob_i,
                               committed: 1'b0, killed: 1'b0};
            tail_q        <= tail_q + 1'b1;
         end
         if (deq) begin
            head_q <= head_q + 1'b1;
         end
         case ({enq_ok, deq})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/ls_exec.sv
// ls_exec: load/store execute stage.
// Accepts one memory op per handshake from the load-store station, computes
// the effective address, performs loads on the data-memory port, parks stores
// in ls_store_buffer until commit, and reports every completion to the CDB.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   issue, rs_data, rt_data, immed, p_rd, rob_num, mem_ren, mem_wen - op in
//   stall_issue                   - op presented this cycle is not accepted
//   recover, rob_num_rec          - flush the op with this ROB tag
//   commit_store                  - oldest store committed by the ROB
//   dmem_*                        - single-outstanding data-memory port
//   cdb_*                         - completion broadcast, held until grant
//   sb_full                       - store buffer full
module ls_exec #(
   parameter int SB_DEPTH = ls_exec_pkg::SB_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [15:0] immed,
   input  logic [5:0]  p_rd,
   input  logic [3:0]  rob_num,
   input  logic        mem_ren,
   input  logic        mem_wen,
   output logic        stall_issue,
   input  logic        recover,
   input  logic [3:0]  rob_num_rec,
   input  logic        commit_store,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        cdb_req,
   input  logic        cdb_grant,
   output logic [31:0] cdb_data,
   output logic [5:0]  cdb_p_rd,
   output logic [3:0]  cdb_rob_num,
   output logic        cdb_RegDest,
   output logic        sb_full
);

   import ls_exec_pkg::*;

   state_e      state_q, state_d;
   port_own_e   own_q, own_d, own_cur;
   logic [31:0] ld_addr_q, ld_addr_d;
   logic [5:0]  ld_prd_q, ld_prd_d;
   logic [3:0]  ld_rob_q, ld_rob_d;
   logic        flushed_q, flushed_d;
   logic [31:0] cdb_data_q, cdb_data_d;
   logic [5:0]  cdb_prd_q, cdb_prd_d;
   logic [3:0]  cdb_rob_q, cdb_rob_d;
   logic        cdb_rd_q, cdb_rd_d;

   logic [31:0] ea;
   logic        accept;
   logic        sb_hazard, sb_drain_req;
   logic [31:0] sb_drain_addr, sb_drain_data;
   logic        load_hit;

   assign ea          = rs_data + {{16{immed[15]}}, immed};
   assign stall_issue = (state_q != IDLE) || sb_full;
   assign accept      = issue && !stall_issue && !recover;
   assign load_hit    = recover && (rob_num_rec == ld_rob_q);

   ls_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
      .clk           (clk),
      .rst           (rst),
      .enq_i         (accept && mem_wen),
      .enq_addr_i    (ea),
      .enq_data_i    (rt_data),
      .enq_rob_i     (rob_num),
      .commit_i      (commit_store),
      .recover_i     (recover),
      .rob_num_rec_i (rob_num_rec),
      .ld_addr_i     (ld_addr_q),
      .drain_ack_i   (dmem_ack && (own_cur == OWN_DRAIN)),
      .full_o        (sb_full),
      .hazard_o      (sb_hazard),
      .drain_req_o   (sb_drain_req),
      .drain_addr_o  (sb_drain_addr),
      .drain_data_o  (sb_drain_data)
   );

   // Port arbiter: ownership is decided only while the port is free and then
   // held until ack, which keeps request/address/data stable. The committed
   // head wins over a load that has not yet requested, so a load waiting on
   // an address hazard cannot deadlock against its own blocking store.
   always_comb begin
      own_cur = own_q;
      if (own_q == OWN_NONE) begin
         if (sb_drain_req) begin
            own_cur = OWN_DRAIN;
         end else if ((state_q == LD) && !sb_hazard) begin
            own_cur = OWN_LOAD;
         end
      end
      own_d = dmem_ack ? OWN_NONE : own_cur;
   end

   always_comb begin
      dmem_req   = (own_cur != OWN_NONE);
      dmem_we    = (own_cur == OWN_DRAIN);
      dmem_addr  = '0;
      dmem_wdata = '0;
      case (own_cur)
         OWN_LOAD:  dmem_addr = ld_addr_q;
         OWN_DRAIN: begin
            dmem_addr  = sb_drain_addr;
            dmem_wdata = sb_drain_data;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      ld_addr_d  = ld_addr_q;
      ld_prd_d   = ld_prd_q;
      ld_rob_d   = ld_rob_q;
      flushed_d  = flushed_q;
      cdb_data_d = cdb_data_q;
      cdb_prd_d  = cdb_prd_q;
      cdb_rob_d  = cdb_rob_q;
      cdb_rd_d   = cdb_rd_q;
      case (state_q)
         IDLE: begin
            if (accept && mem_ren) begin
               ld_addr_d = ea;
               ld_prd_d  = p_rd;
               ld_rob_d  = rob_num;
               flushed_d = 1'b0;
               state_d   = LD;
            end else if (accept && mem_wen) begin
               cdb_data_d = '0;
               cdb_prd_d  = '0;
               cdb_rob_d  = rob_num;
               cdb_rd_d   = 1'b0;
               state_d    = CDB;
            end
         end
         LD: begin
            if (own_cur == OWN_LOAD) begin
               // A request is in flight: a flush must wait for the ack and
               // then silently discard the returned data.
               if (dmem_ack) begin
                  flushed_d = 1'b0;
                  if (flushed_q || load_hit) begin
                     state_d = IDLE;
                  end else begin
                     cdb_data_d = dmem_rdata;
                     cdb_prd_d  = ld_prd_q;
                     cdb_rob_d  = ld_rob_q;
                     cdb_rd_d   = 1'b1;
                     state_d    = CDB;
                  end
               end else if (load_hit) begin
                  flushed_d = 1'b1;
               end
            end else if (load_hit) begin
               state_d = IDLE;
            end
         end
         CDB: begin
            if (cdb_grant || (recover && (rob_num_rec == cdb_rob_q))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         own_q      <= OWN_NONE;
         ld_addr_q  <= '0;
         ld_prd_q   <= '0;
         ld_rob_q   <= '0;
         flushed_q  <= 1'b0;
         cdb_data_q <= '0;
         cdb_prd_q  <= '0;
         cdb_rob_q  <= '0;
         cdb_rd_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         own_q      <= own_d;
         ld_addr_q  <= ld_addr_d;
         ld_prd_q   <= ld_prd_d;
         ld_rob_q   <= ld_rob_d;
         flushed_q  <= flushed_d;
         cdb_data_q <= cdb_data_d;
         cdb_prd_q  <= cdb_prd_d;
         cdb_rob_q  <= cdb_rob_d;
         cdb_rd_q   <= cdb_rd_d;
      end
   end

   assign cdb_req     = (state_q == CDB);
   assign cdb_data    = cdb_data_q;
   assign cdb_p_rd    = cdb_prd_q;
   assign cdb_rob_num = cdb_rob_q;
   assign cdb_RegDest = cdb_rd_q;

endmodule

// File: tb/tb_ls_exec.sv
// tb_ls_exec: directed self-checking bench for ls_exec.
// Inputs change 2 time units after the rising edge; outputs are sampled one
// unit later. Completed memory writes are logged at the falling edge.
module tb_ls_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue = 1'b0;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic [15:0] immed = '0;
   logic [5:0]  p_rd = '0;
   logic [3:0]  rob_num = '0;
   logic        mem_ren = 1'b0;
   logic        mem_wen = 1'b0;
   logic        stall_issue;
   logic        recover = 1'b0;
   logic [3:0]  rob_num_rec = '0;
   logic        commit_store = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        cdb_req;
   logic        cdb_grant = 1'b0;
   logic [31:0] cdb_data;
   logic [5:0]  cdb_p_rd;
   logic [3:0]  cdb_rob_num;
   logic        cdb_RegDest;
   logic        sb_full;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] wr_addr_log[$];
   logic [31:0] wr_data_log[$];

   always #5 clk = ~clk;

   ls_exec dut (
      .clk          (clk),
      .rst          (rst),
      .issue        (issue),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .immed        (immed),
      .p_rd         (p_rd),
      .rob_num      (rob_num),
      .mem_ren      (mem_ren),
      .mem_wen      (mem_wen),
      .stall_issue  (stall_issue),
      .recover      (recover),
      .rob_num_rec  (rob_num_rec),
      .commit_store (commit_store),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_ack     (dmem_ack),
      .dmem_rdata   (dmem_rdata),
      .cdb_req      (cdb_req),
      .cdb_grant    (cdb_grant),
      .cdb_data     (cdb_data),
      .cdb_p_rd     (cdb_p_rd),
      .cdb_rob_num  (cdb_rob_num),
      .cdb_RegDest  (cdb_RegDest),
      .sb_full      (sb_full)
   );

   always @(negedge clk) begin
      if (rst && dmem_req && dmem_ack && dmem_we) begin
         wr_addr_log.push_back(dmem_addr);
         wr_data_log.push_back(dmem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   // Present one op for one cycle; returns just after the accepting edge.
   task automatic drive_op(input logic is_load, input logic [31:0] base,
                           input logic [15:0] off, input logic [31:0] wdata,
                           input logic [5:0] prd, input logic [3:0] rob);
      issue   = 1'b1;
      mem_ren = is_load;
      mem_wen = !is_load;
      rs_data = base;
      immed   = off;
      rt_data = wdata;
      p_rd    = prd;
      rob_num = rob;
      settle();
      check("stall_at_issue", {31'b0, stall_issue}, 32'd0);
      next_cycle();
      issue   = 1'b0;
      mem_ren = 1'b0;
      mem_wen = 1'b0;
   endtask

   // Store accepted, its CDB report granted immediately.
   task automatic store_op(input logic [31:0] base, input logic [15:0] off,
                           input logic [31:0] wdata, input logic [3:0] rob);
      drive_op(1'b0, base, off, wdata, 6'd0, rob);
      cdb_grant = 1'b1;
      settle();
      check("st_cdb_req", {31'b0, cdb_req}, 32'd1);
      check("st_cdb_regdest", {31'b0, cdb_RegDest}, 32'd0);
      check("st_cdb_rob", {28'b0, cdb_rob_num}, {28'b0, rob});
      next_cycle();
      cdb_grant = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int blocked;

      // ---------------- reset state
      rst = 1'b1;
      #1 rst = 1'b0;
      #2;
      check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      check("rst_dmem_addr", dmem_addr, 32'd0);
      check("rst_cdb_req", {31'b0, cdb_req}, 32'd0);
      check("rst_cdb_data", cdb_data, 32'd0);
      check("rst_stall", {31'b0, stall_issue}, 32'd0);
      check("rst_sb_full", {31'b0, sb_full}, 32'd0);
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // ---------------- load, zero-wait memory, negative offset
      drive_op(1'b1, 32'h0000_0100, 16'hFFFC, 32'd0, 6'd5, 4'd3);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      settle();
      check("ld_req", {31'b0, dmem_req}, 32'd1);
      check("ld_addr", dmem_addr, 32'h0000_00FC);
      check("ld_we", {31'b0, dmem_we}, 32'd0);
      check("ld_cdb_early", {31'b0, cdb_req}, 32'd0);
      next_cycle();
      dmem_ack = 1'b0;
      settle();
      check("ld_cdb_req", {31'b0, cdb_req}, 32'd1);
      check("ld_cdb_data", cdb_data, 32'hDEAD_BEEF);
      check("ld_cdb_prd", {26'b0, cdb_p_rd}, 32'd5);
      check("ld_cdb_rob", {28'b0, cdb_rob_num}, 32'd3);
      check("ld_cdb_regdest", {31'b0, cdb_RegDest}, 32'd1);
      check("ld_busy_stall", {31'b0, stall_issue}, 32'd1);
      cdb_grant = 1'b1;
      next_cycle();
      cdb_grant = 1'b0;
      settle();
      check("ld_done_cdb", {31'b0, cdb_req}, 32'd0);
      check("ld_done_stall", {31'b0, stall_issue}, 32'd0);

      // ---------------- fill the store buffer
      for (int k = 0; k < 4; k++) begin
         store_op(32'h0000_0300, 16'(k * 4), 32'h0000_00A0 + 32'(k), 4'(4 + k));
      end
      settle();
      check("sb_full", {31'b0, sb_full}, 32'd1);
      check("full_stall", {31'b0, stall_issue}, 32'd1);
      issue   = 1'b1;
      mem_wen = 1'b1;
      rob_num = 4'd9;
      next_cycle();
      issue   = 1'b0;
      mem_wen = 1'b0;
      settle();
      check("full_no_accept", {31'b0, cdb_req}, 32'd0);
      check("full_no_write", {31'b0, dmem_req}, 32'd0);

      commit_store = 1'b1;
      next_cycle();
      commit_store = 1'b0;
      settle();
      check("drain_req", {31'b0, dmem_req}, 32'd1);
      check("drain_we", {31'b0, dmem_we}, 32'd1);
      check("drain_addr", dmem_addr, 32'h0000_0300);
      check("drain_wdata", dmem_wdata, 32'h0000_00A0);
      next_cycle();
      settle();
      check("drain_hold_req", {31'b0, dmem_req}, 32'd1);
      check("drain_hold_addr", dmem_addr, 32'h0000_0300);
      dmem_ack = 1'b1;
      settle();
      check("full_before_ack", {31'b0, sb_full}, 32'd1);
      next_cycle();
      dmem_ack = 1'b0;
      settle();
      check("full_after_ack", {31'b0, sb_full}, 32'd0);
      check("no_uncommitted_write", {31'b0, dmem_req}, 32'd0);

      commit_store = 1'b1;
      dmem_ack     = 1'b1;
      repeat (3) next_cycle();
      commit_store = 1'b0;
      repeat (3) next_cycle();
      dmem_ack = 1'b0;
      settle();
      check("drain_count", 32'(wr_addr_log.size()), 32'd4);
      check("drain_order_addr1", wr_addr_log[1], 32'h0000_0304);
      check("drain_order_addr3", wr_addr_log[3], 32'h0000_030C);
      check("drain_order_data3", wr_data_log[3], 32'h0000_00A3);

      // ---------------- load blocked by an uncommitted store to same word
      store_op(32'h0000_0200, 16'h0000, 32'h0000_0055, 4'd1);
      drive_op(1'b1, 32'h0000_0200, 16'h0002, 32'd0, 6'd7, 4'd2);
      settle();
      blocked = 0;
      for (int i = 0; i < 4; i++) begin
         if (dmem_req) blocked++;
         next_cycle();
         settle();
      end
      check("hazard_blocks_load", 32'(blocked), 32'd0);
      commit_store = 1'b1;
      next_cycle();
      commit_store = 1'b0;
      dmem_ack     = 1'b1;
      dmem_rdata   = 32'h1234_5678;
      settle();
      check("hz_write_first_we", {31'b0, dmem_we}, 32'd1);
      check("hz_write_addr", dmem_addr, 32'h0000_0200);
      check("hz_write_data", dmem_wdata, 32'h0000_0055);
      next_cycle();
      settle();
      check("hz_load_req", {31'b0, dmem_req}, 32'd1);
      check("hz_load_we", {31'b0, dmem_we}, 32'd0);
      check("hz_load_addr", dmem_addr, 32'h0000_0202);
      next_cycle();
      dmem_ack = 1'b0;
      settle();
      check("hz_cdb_req", {31'b0, cdb_req}, 32'd1);
      check("hz_cdb_data", cdb_data, 32'h1234_5678);
      check("hz_cdb_prd", {26'b0, cdb_p_rd}, 32'd7);
      cdb_grant = 1'b1;
      next_cycle();
      cdb_grant = 1'b0;

      // ---------------- flush of a load with its request outstanding
      drive_op(1'b1, 32'h0000_0400, 16'h0000, 32'd0, 6'd9, 4'd6);
      settle();
      check("fl_req", {31'b0, dmem_req}, 32'd1);
      check("fl_addr", dmem_addr, 32'h0000_0400);
      recover     = 1'b1;
      rob_num_rec = 4'd6;
      next_cycle();
      recover = 1'b0;
      settle();
      check("fl_req_held", {31'b0, dmem_req}, 32'd1);
      check("fl_still_busy", {31'b0, stall_issue}, 32'd1);
      next_cycle();
      next_cycle();
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      next_cycle();
      dmem_ack = 1'b0;
      settle();
      check("fl_no_cdb", {31'b0, cdb_req}, 32'd0);
      check("fl_idle", {31'b0, stall_issue}, 32'd0);
      check("fl_port_free", {31'b0, dmem_req}, 32'd0);
      next_cycle();
      settle();
      check("fl_no_cdb_later", {31'b0, cdb_req}, 32'd0);

      // ---------------- kill the middle of three stores
      store_op(32'h0000_0500, 16'h0000, 32'h0000_00B0, 4'd10);
      store_op(32'h0000_0500, 16'h0004, 32'h0000_00B1, 4'd11);
      store_op(32'h0000_0500, 16'h0008, 32'h0000_00B2, 4'd12);
      recover     = 1'b1;
      rob_num_rec = 4'd11;
      next_cycle();
      recover = 1'b0;
      wr_addr_log.delete();
      wr_data_log.delete();
      commit_store = 1'b1;
      dmem_ack     = 1'b1;
      next_cycle();
      commit_store = 1'b0;
      next_cycle();
      commit_store = 1'b1;
      next_cycle();
      commit_store = 1'b0;
      repeat (4) next_cycle();
      dmem_ack = 1'b0;
      settle();
      check("kill_write_count", 32'(wr_addr_log.size()), 32'd2);
      check("kill_first_addr", wr_addr_log[0], 32'h0000_0500);
      check("kill_second_addr", wr_addr_log[1], 32'h0000_0508);
      check("kill_second_data", wr_data_log[1], 32'h0000_00B2);
      check("kill_port_idle", {31'b0, dmem_req}, 32'd0);

      // ---------------- recover a store waiting in CDB state
      drive_op(1'b0, 32'h0000_0700, 16'h0000, 32'h0000_00C0, 6'd0, 4'd13);
      recover     = 1'b1;
      rob_num_rec = 4'd13;
      settle();
      check("cdb_rec_before", {31'b0, cdb_req}, 32'd1);
      next_cycle();
      recover = 1'b0;
      settle();
      check("cdb_rec_dropped", {31'b0, cdb_req}, 32'd0);
      check("cdb_rec_idle", {31'b0, stall_issue}, 32'd0);

      // ---------------- reset in the middle of a load request
      drive_op(1'b1, 32'h0000_0600, 16'h0000, 32'd0, 6'd3, 4'd7);
      settle();
      check("rstld_req_before", {31'b0, dmem_req}, 32'd1);
      rst = 1'b0;
      settle();
      check("rstld_req", {31'b0, dmem_req}, 32'd0);
      check("rstld_addr", dmem_addr, 32'd0);
      check("rstld_cdb", {31'b0, cdb_req}, 32'd0);
      check("rstld_stall", {31'b0, stall_issue}, 32'd0);
      next_cycle();
      rst = 1'b1;
      next_cycle();
      settle();
      check("rstld_after_stall", {31'b0, stall_issue}, 32'd0);
      check("rstld_after_req", {31'b0, dmem_req}, 32'd0);
      check("rstld_after_full", {31'b0, sb_full}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
